hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage core: drives enable/flush on IF/ID, ID/EX,
//  EX/MEM and MEM/WB, plus PC enable. Consumes decode (_id) and execute (_ex)

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives stage fields), slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             mem2reg_ex;
  logic             RegWr_ex;
  logic [4:0]       wsel_ex;
  logic [4:0]       Rs_id;
  logic [4:0]       Rt_id;
  logic             rt_used_id;
  logic             redirect_ex;
  logic             halt_mem;
  logic             pc_en;
  logic             enable_ifid;
  logic             flush_ifid;
  logic             enable_idex;
  logic             flush_idex;
  logic             enable_exmem;
  logic             flush_exmem;
  logic             enable_memwb;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, mem2reg_ex, RegWr_ex, wsel_ex,
           Rs_id, Rt_id, rt_used_id, redirect_ex, halt_mem,
    input  pc_en, enable_ifid, flush_ifid, enable_idex, flush_idex,
           enable_exmem, flush_exmem, enable_memwb, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, mem2reg_ex, RegWr_ex, wsel_ex,
           Rs_id, Rt_id, rt_used_id, redirect_ex, halt_mem,
    output pc_en, enable_ifid, flush_ifid, enable_idex, flush_idex,
           enable_exmem, flush_exmem, enable_memwb, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, load-use bubble, halt latch
// and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  hazard_ctrl_if.slave        bus,
  output logic [1:0]          state_o
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memwait, ldhaz, redirect_taken, stall_inc;
  logic pc_en, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb;

  always_comb begin
    memwait = (bus.dREN_mem | bus.dWEN_mem) & ~bus.dhit;
    ldhaz   = bus.mem2reg_ex & bus.RegWr_ex & (bus.wsel_ex != 5'd0) &
              ((bus.wsel_ex == bus.Rs_id) |
               (bus.rt_used_id & (bus.wsel_ex == bus.Rt_id)));

    pc_en          = 1'b1;
    en_ifid        = 1'b1;
    fl_ifid        = 1'b0;
    en_idex        = 1'b1;
    fl_idex        = 1'b0;
    en_exmem       = 1'b1;
    fl_exmem       = 1'b0;
    en_memwb       = 1'b1;
    state_d        = state_q;
    redirect_taken = 1'b0;

    if (state_q == HALT || bus.halt_mem || memwait) begin
      // Full freeze; a halt in MEM must not be written back.
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
      if (state_q != HALT && bus.halt_mem) state_d = HALT;
    end else if (bus.redirect_ex) begin
      // Squashing ID also squashes any pending load-use consumer.
      fl_ifid        = 1'b1;
      fl_idex        = 1'b1;
      state_d        = RUN;
      redirect_taken = 1'b1;
    end else if (ldhaz && state_q == RUN) begin
      pc_en   = 1'b0;
      en_ifid = 1'b0;
      fl_idex = 1'b1;
      state_d = LDUSE;
    end else if (state_q != RUN) begin
      state_d = RUN;
    end else if (!bus.ihit) begin
      pc_en   = 1'b0;
      fl_ifid = 1'b1;
    end

    stall_inc   = ~pc_en & (state_q != HALT) & ~bus.halt_mem;
    stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (redirect_taken && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.enable_ifid  = en_ifid;
  assign bus.flush_ifid   = fl_ifid;
  assign bus.enable_idex  = en_idex;
  assign bus.flush_idex   = fl_idex;
  assign bus.enable_exmem = en_exmem;
  assign bus.flush_exmem  = fl_exmem;
  assign bus.enable_memwb = en_memwb;
  assign bus.halted       = (state_q == HALT);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a priority-rule model.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_vec;
  int         n_fail;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK     (clk),
    .RST     (rst),
    .bus     (hif.slave),
    .state_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: halted flag, "bubble already inserted" flag, counters
  bit m_valid;
  bit m_halted;
  bit m_bubble;
  int m_stall;
  int m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which priority rule applies this cycle (1..8).
  function automatic int pick_rule();
    logic memwait, ldhaz;
    memwait = (hif.dREN_mem | hif.dWEN_mem) & ~hif.dhit;
    ldhaz   = hif.mem2reg_ex & hif.RegWr_ex & (hif.wsel_ex != 0) &
              ((hif.wsel_ex == hif.Rs_id) | (hif.rt_used_id & (hif.wsel_ex == hif.Rt_id)));
    if (m_halted)                 return 1;
    if (hif.halt_mem)             return 2;
    if (memwait)                  return 3;
    if (hif.redirect_ex)          return 4;
    if (ldhaz && !m_bubble)       return 5;
    if (m_bubble)                 return 6;
    if (!hif.ihit)                return 7;
    return 8;
  endfunction

  // {pc_en, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb}
  function automatic logic [7:0] rule_ctl(input int r);
    case (r)
      1, 2, 3: return 8'b0000_0000;
      4:       return 8'b1111_1101;
      5:       return 8'b0001_1101;
      7:       return 8'b0111_0101;
      default: return 8'b1101_0101;
    endcase
  endfunction

  // model update on the active edge
  always @(posedge clk) begin
    int r;
    logic [7:0] c;
    if (rst) begin
      m_valid  = 1'b1;
      m_halted = 1'b0;
      m_bubble = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
    end else if (m_valid) begin
      r = pick_rule();
      c = rule_ctl(r);
      if (!c[7] && !m_halted && !hif.halt_mem && m_stall < MAXC) m_stall++;
      if (r == 4 && m_flush < MAXC) m_flush++;
      case (r)
        2: m_halted = 1'b1;
        4: m_bubble = 1'b0;
        5: m_bubble = 1'b1;
        6: m_bubble = 1'b0;
        default: ;
      endcase
    end
  end

  // scoreboard compare on the inactive edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("ctl", {hif.pc_en, hif.enable_ifid, hif.flush_ifid, hif.enable_idex,
                    hif.flush_idex, hif.enable_exmem, hif.flush_exmem, hif.enable_memwb},
            rule_ctl(pick_rule()));
      check("halted", hif.halted, m_halted);
      check("stall_cnt", hif.stall_cnt, m_stall);
      check("flush_cnt", hif.flush_cnt, m_flush);
    end
  end

  // driver tasks
  task automatic idle();
    hif.ihit = 1'b1; hif.dhit = 1'b0; hif.dREN_mem = 1'b0; hif.dWEN_mem = 1'b0;
    hif.mem2reg_ex = 1'b0; hif.RegWr_ex = 1'b0; hif.wsel_ex = 5'd0;
    hif.Rs_id = 5'd0; hif.Rt_id = 5'd0; hif.rt_used_id = 1'b0;
    hif.redirect_ex = 1'b0; hif.halt_mem = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] w, input logic [4:0] rs, input logic [4:0] rt,
                            input logic rt_used);
    hif.mem2reg_ex = 1'b1; hif.RegWr_ex = 1'b1; hif.wsel_ex = w;
    hif.Rs_id = rs; hif.Rt_id = rt; hif.rt_used_id = rt_used;
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    m_valid = 1'b0; m_halted = 1'b0; m_bubble = 1'b0; m_stall = 0; m_flush = 0;
    rst = 1'b1;
    idle();

    // T1: two reset cycles
    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    check("t1_ctl", {hif.pc_en, hif.enable_ifid, hif.enable_idex, hif.enable_exmem,
                     hif.enable_memwb, hif.flush_ifid, hif.flush_idex, hif.flush_exmem},
          8'b1111_1000);
    check("t1_cnt", {hif.stall_cnt, hif.flush_cnt, 3'b000, hif.halted}, 0);

    // T2: load-use stall, exactly one bubble
    next_cycle();
    load_in_ex(5'd5, 5'd5, 5'd9, 1'b0);
    settle();
    check("t2_pc_en", hif.pc_en, 0);
    check("t2_en_ifid", hif.enable_ifid, 0);
    check("t2_flush_idex", hif.flush_idex, 1);
    next_cycle();
    settle();
    check("t2_adv_pc_en", hif.pc_en, 1);
    check("t2_adv_flush_idex", hif.flush_idex, 0);
    check("t2_stall_cnt", hif.stall_cnt, 1);

    // T3: load writing $0 never stalls
    next_cycle();
    load_in_ex(5'd0, 5'd0, 5'd0, 1'b1);
    settle();
    check("t3_pc_en", hif.pc_en, 1);
    check("t3_flush_idex", hif.flush_idex, 0);

    // T4: dcache miss freezes a pending redirect
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hif.dREN_mem = 1'b1; hif.dhit = 1'b0; hif.redirect_ex = 1'b1;
      settle();
      check("t4_freeze", {hif.pc_en, hif.enable_ifid, hif.enable_idex, hif.enable_exmem,
                          hif.enable_memwb, hif.flush_ifid, hif.flush_idex}, 0);
      next_cycle();
    end
    hif.dREN_mem = 1'b0;
    settle();
    check("t4_redirect", {hif.pc_en, hif.flush_ifid, hif.flush_idex}, 3'b111);
    check("t4_stall_cnt", hif.stall_cnt, 3);
    next_cycle();
    idle();
    settle();
    check("t4_flush_cnt", hif.flush_cnt, 1);
    check("t4_stall_hold", hif.stall_cnt, 3);

    // T5: redirect beats load-use, no bubble pending afterwards
    next_cycle();
    load_in_ex(5'd7, 5'd3, 5'd7, 1'b1);
    hif.redirect_ex = 1'b1;
    settle();
    check("t5_redirect", {hif.pc_en, hif.enable_ifid, hif.flush_ifid, hif.flush_idex}, 4'b1111);
    next_cycle();
    hif.redirect_ex = 1'b0;
    settle();
    check("t5_still_run", hif.pc_en, 0);
    next_cycle();
    idle();

    // T6: stall counter saturation, then halt
    do_reset();
    hif.ihit = 1'b0;
    for (int i = 0; i < 20; i++) next_cycle();
    settle();
    check("t6_sat", hif.stall_cnt, 15);
    next_cycle();
    hif.ihit = 1'b1;
    hif.halt_mem = 1'b1;
    settle();
    check("t6_halt_cycle", {hif.pc_en, hif.enable_memwb, hif.halted}, 0);
    next_cycle();
    hif.halt_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t6_halted", {hif.halted, hif.pc_en, hif.enable_ifid, hif.enable_memwb}, 4'b1000);
      next_cycle();
    end
    do_reset();
    settle();
    check("t6_reset", {hif.halted, hif.stall_cnt}, 0);

    // randomized traffic, small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst             = ($urandom_range(0, 99) < 2);
      hif.ihit        = ($urandom_range(0, 9) != 0);
      hif.dhit        = ($urandom_range(0, 3) != 0);
      hif.dREN_mem    = ($urandom_range(0, 3) == 0);
      hif.dWEN_mem    = ($urandom_range(0, 5) == 0);
      hif.mem2reg_ex  = ($urandom_range(0, 1) == 1);
      hif.RegWr_ex    = ($urandom_range(0, 3) != 0);
      hif.wsel_ex     = 5'($urandom_range(0, 3));
      hif.Rs_id       = 5'($urandom_range(0, 3));
      hif.Rt_id       = 5'($urandom_range(0, 3));
      hif.rt_used_id  = ($urandom_range(0, 1) == 1);
      hif.redirect_ex = ($urandom_range(0, 9) == 0);
      hif.halt_mem    = ($urandom_range(0, 199) == 0);
    end
    next_cycle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
